// File: rtl/icache_burst_pkg.sv
// Shared definitions for the burst-refill instruction cache.
// Holds the controller state encoding and the address field helpers.
// The helpers work on a 64-bit zero-extended word address and take the
// geometry as arguments, so callers size the result with a cast:
//   getOffset : word offset inside a line, bits [lineScale-1:0]
//   getIndex  : line index, bits [scale-1:lineScale]
//   getTag    : tag, bits [addrWidth-1:scale]
package icache_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQ,
    ST_FILL,
    ST_RESP
  } state_t;

  function automatic logic [63:0] getOffset(input logic [63:0] a, input int lineScale);
    return a & ((64'd1 << lineScale) - 64'd1);
  endfunction

  function automatic logic [63:0] getIndex(input logic [63:0] a, input int scale,
                                           input int lineScale);
    return (a >> lineScale) & ((64'd1 << (scale - lineScale)) - 64'd1);
  endfunction

  function automatic logic [63:0] getTag(input logic [63:0] a, input int scale);
    return a >> scale;
  endfunction

endpackage

// File: rtl/icache_burst_dpram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port,
// same clock. Contents are not initialised; the cache only trusts an entry
// once its line-valid bit is set. Reading an address being written in the
// same cycle returns the old contents.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (registered)
//   o_rdata  read data, one cycle after i_raddr
module icache_burst_dpram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [1 << AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/icache_burst_valid_bits.sv
// Per-line valid flags for the instruction cache.
// A flush clears every flag on the next edge and beats a coincident set, so a
// line finishing its refill in the same cycle as a flush stays invalid.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (all flags cleared)
//   i_set      mark line i_setIdx valid
//   i_setIdx   line to mark
//   i_flush    clear all flags
//   i_readIdx  line to look up
//   o_valid    flag of line i_readIdx (combinational)
module icache_valid_bits #(
  parameter int LINES = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set,
  input  logic [IDX_W-1:0] i_setIdx,
  input  logic             i_flush,
  input  logic [IDX_W-1:0] i_readIdx,
  output logic             o_valid
);

  logic [LINES-1:0] r_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bits <= '0;
    end else if (i_flush) begin
      r_bits <= '0;
    end else if (i_set) begin
      r_bits[i_setIdx] <= 1'b1;
    end
  end

  assign o_valid = r_bits[i_readIdx];

endmodule

// File: rtl/icache_burst.sv
// Direct-mapped instruction cache with multi-word lines and burst refill.
// A fetch is accepted with oe while ready is high; a hit answers one cycle
// later, a miss issues a one-cycle burst request for the whole line, writes
// the returned words in ascending order, then re-runs the lookup.
// Optional statistics counters are built when ICACHE_STAT_EN is defined;
// otherwise the counter ports read zero.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   oe, addr          fetch request and word address
//   ready             fetch can be accepted this cycle
//   rdata, valid      instruction for the last accepted address
//   super_oe          one-cycle burst request to DRAM
//   super_addr        line-aligned burst base address
//   super_rdata       refill word
//   super_valid       one refill word per pulse
//   clear             invalidate all lines
//   ic_cnt_hit        first-lookup hits
//   ic_cnt_access     accepted fetches
//   ic_cnt_refill     burst requests
module icache_burst
  import icache_burst_pkg::*;
#(
  parameter int MEM_SCALE  = 27,
  parameter int SCALE      = 10,
  parameter int LINE_SCALE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 oe,
  input  logic [MEM_SCALE-1:0] addr,
  output logic                 ready,
  output logic [31:0]          rdata,
  output logic                 valid,
  output logic                 super_oe,
  output logic [MEM_SCALE-1:0] super_addr,
  input  logic [31:0]          super_rdata,
  input  logic                 super_valid,
  input  logic                 clear,
  output logic [31:0]          ic_cnt_hit,
  output logic [31:0]          ic_cnt_access,
  output logic [31:0]          ic_cnt_refill
);

  localparam int IDX_W = SCALE - LINE_SCALE;
  localparam int TAG_W = MEM_SCALE - SCALE;
  localparam int LINES = 1 << IDX_W;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [MEM_SCALE-1:0]   r_lastAddr;
  logic [LINE_SCALE-1:0]  r_wordCnt;
  logic                   r_dropPending;

  logic                   w_accept;
  logic [MEM_SCALE-1:0]   w_rdSrc;
  logic [IDX_W-1:0]       w_rdIndex;
  logic [LINE_SCALE-1:0]  w_rdOffset;
  logic [IDX_W-1:0]       w_lastIndex;
  logic [TAG_W-1:0]       w_lastTag;
  logic [TAG_W-1:0]       w_tagRd;
  logic                   w_lineValid;
  logic                   w_hit;
  logic                   w_fillWe;
  logic                   w_lineDone;
  logic                   w_lineCommit;

  assign w_accept    = oe && ready;
  // The RAMs are read one cycle ahead of the lookup, so a newly accepted
  // address must steer the read port directly rather than via r_lastAddr.
  assign w_rdSrc     = w_accept ? addr : r_lastAddr;
  assign w_rdIndex   = IDX_W'(getIndex(64'(w_rdSrc), SCALE, LINE_SCALE));
  assign w_rdOffset  = LINE_SCALE'(getOffset(64'(w_rdSrc), LINE_SCALE));
  assign w_lastIndex = IDX_W'(getIndex(64'(r_lastAddr), SCALE, LINE_SCALE));
  assign w_lastTag   = TAG_W'(getTag(64'(r_lastAddr), SCALE));

  assign w_hit        = w_lineValid && (w_tagRd == w_lastTag);
  assign w_fillWe     = (r_state == ST_FILL) && super_valid;
  assign w_lineDone   = w_fillWe && (r_wordCnt == '1);
  // A clear seen during this refill means the line must not become valid.
  assign w_lineCommit = w_lineDone && !r_dropPending;

  assign super_addr = {r_lastAddr[MEM_SCALE-1:LINE_SCALE], {LINE_SCALE{1'b0}}};

  icache_burst_dpram #(
    .AW(SCALE),
    .DW(32)
  ) u_dataRam (
    .clk    (clk),
    .i_we   (w_fillWe),
    .i_waddr({w_lastIndex, r_wordCnt}),
    .i_wdata(super_rdata),
    .i_raddr({w_rdIndex, w_rdOffset}),
    .o_rdata(rdata)
  );

  icache_burst_dpram #(
    .AW(IDX_W),
    .DW(TAG_W)
  ) u_tagRam (
    .clk    (clk),
    .i_we   (w_lineCommit),
    .i_waddr(w_lastIndex),
    .i_wdata(w_lastTag),
    .i_raddr(w_rdIndex),
    .o_rdata(w_tagRd)
  );

  icache_valid_bits #(
    .LINES(LINES),
    .IDX_W(IDX_W)
  ) u_validBits (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_set    (w_lineCommit),
    .i_setIdx (w_lastIndex),
    .i_flush  (clear),
    .i_readIdx(w_lastIndex),
    .o_valid  (w_lineValid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_lastAddr    <= '0;
      r_wordCnt     <= '0;
      r_dropPending <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_lastAddr <= addr;
      end
      if (r_state == ST_REQ) begin
        r_wordCnt <= '0;
      end else if (w_fillWe) begin
        r_wordCnt <= r_wordCnt + LINE_SCALE'(1);
      end
      // Leaving FILL always retires the pending drop, even if a clear
      // arrives with the last word; the flush itself keeps that line invalid.
      if (r_state == ST_FILL && w_nextState != ST_FILL) begin
        r_dropPending <= 1'b0;
      end else if (clear && (r_state == ST_REQ || r_state == ST_FILL)) begin
        r_dropPending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    ready       = 1'b0;
    valid       = 1'b0;
    super_oe    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (oe) begin
          w_nextState = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (w_hit) begin
          valid       = 1'b1;
          ready       = 1'b1;
          w_nextState = oe ? ST_LOOKUP : ST_IDLE;
        end else begin
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        super_oe    = 1'b1;
        w_nextState = ST_FILL;
      end
      ST_FILL: begin
        if (w_lineDone) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        w_nextState = ST_LOOKUP;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

`ifdef ICACHE_STAT_EN
  logic [31:0] r_cntHit;
  logic [31:0] r_cntAccess;
  logic [31:0] r_cntRefill;
  logic        r_prevResp;

  // A lookup straight after RESP is the re-lookup of a refilled line and is
  // not counted as a hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cntHit    <= 32'd0;
      r_cntAccess <= 32'd0;
      r_cntRefill <= 32'd0;
      r_prevResp  <= 1'b0;
    end else begin
      r_prevResp <= (r_state == ST_RESP);
      if (w_accept) begin
        r_cntAccess <= r_cntAccess + 32'd1;
      end
      if (r_state == ST_LOOKUP && w_hit && !r_prevResp) begin
        r_cntHit <= r_cntHit + 32'd1;
      end
      if (super_oe) begin
        r_cntRefill <= r_cntRefill + 32'd1;
      end
    end
  end

  assign ic_cnt_hit    = r_cntHit;
  assign ic_cnt_access = r_cntAccess;
  assign ic_cnt_refill = r_cntRefill;
`else
  assign ic_cnt_hit    = 32'b0;
  assign ic_cnt_access = 32'b0;
  assign ic_cnt_refill = 32'b0;
`endif

endmodule

// File: tb/tb_icache_burst.sv
// Directed bench for icache_burst with a line-level cache model and a
// scoreboard of expected instructions and expected burst addresses.
module tb_icache_burst;

  localparam int MEM_SCALE  = 27;
  localparam int SCALE      = 10;
  localparam int LINE_SCALE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        oe = 1'b0;
  logic [26:0] addr = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        valid;
  logic        super_oe;
  logic [26:0] super_addr;
  logic [31:0] super_rdata = '0;
  logic        super_valid = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ic_cnt_hit;
  logic [31:0] ic_cnt_access;
  logic [31:0] ic_cnt_refill;

  icache_burst #(
    .MEM_SCALE (MEM_SCALE),
    .SCALE     (SCALE),
    .LINE_SCALE(LINE_SCALE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .oe           (oe),
    .addr         (addr),
    .ready        (ready),
    .rdata        (rdata),
    .valid        (valid),
    .super_oe     (super_oe),
    .super_addr   (super_addr),
    .super_rdata  (super_rdata),
    .super_valid  (super_valid),
    .clear        (clear),
    .ic_cnt_hit   (ic_cnt_hit),
    .ic_cnt_access(ic_cnt_access),
    .ic_cnt_refill(ic_cnt_refill)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nErrors = 0;

  logic [31:0] expQ[$];
  logic [26:0] refillQ[$];
  logic [26:0] lastSuperAddr = '0;
  int          tOe = 0;
  int          lastWordCyc = 0;

  bit          mValid[256];
  logic [16:0] mTag[256];

  // DRAM contents: every word address holds a distinct, easily derived value.
  function automatic logic [31:0] memWord(input logic [26:0] a);
    return {5'b10101, a};
  endfunction

  function automatic bit modelHit(input logic [26:0] a);
    return mValid[a[9:2]] && (mTag[a[9:2]] == a[26:10]);
  endfunction

  task automatic modelFill(input logic [26:0] a);
    mValid[a[9:2]] = 1'b1;
    mTag[a[9:2]]   = a[26:10];
  endtask

  task automatic modelClear();
    foreach (mValid[i]) mValid[i] = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Every cycle: an asserted valid must deliver the oldest outstanding fetch,
  // an asserted super_oe must target the oldest expected refill line.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (expQ.size() == 0) checkOutput("valid without pending fetch", 32'(valid), 32'd0);
        else checkOutput("rdata", rdata, expQ.pop_front());
      end
      if (super_oe) begin
        lastSuperAddr = super_addr;
        if (refillQ.size() == 0)
          checkOutput("super_oe without expected miss", 32'(super_oe), 32'd0);
        else checkOutput("super_addr", 32'(super_addr), 32'(refillQ.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    for (int k = 0; k < 50 && !ready; k++) step();
    if (!ready) checkOutput("ready timeout", 32'(ready), 32'd1);
  endtask

  task automatic waitSuperOe();
    for (int k = 0; k < 50 && !super_oe; k++) step();
    if (!super_oe) checkOutput("super_oe timeout", 32'(super_oe), 32'd1);
  endtask

  task automatic waitValid();
    for (int k = 0; k < 50 && !valid; k++) step();
    if (!valid) checkOutput("valid timeout", 32'(valid), 32'd1);
  endtask

  // Present one fetch for one cycle and record what the model expects.
  task automatic applyStimulus(input logic [26:0] a);
    waitReady();
    oe   = 1'b1;
    addr = a;
    tOe  = cyc;
    if (!modelHit(a)) refillQ.push_back({a[26:2], 2'b00});
    expQ.push_back(memWord(a));
    step();
    oe = 1'b0;
  endtask

  task automatic serveBurst(input logic [26:0] base, input int clearAt);
    for (int i = 0; i < 4; i++) begin
      super_valid = 1'b1;
      super_rdata = memWord(base | 27'(i));
      clear       = (i == clearAt);
      lastWordCyc = cyc;
      step();
    end
    super_valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic fetchHit(input logic [26:0] a);
    applyStimulus(a);
    checkOutput($sformatf("hit valid %h", a), 32'(valid), 32'd1);
    checkOutput($sformatf("hit no super_oe %h", a), 32'(super_oe), 32'd0);
  endtask

  // Miss with optional clear during the burst (clearAt = word number, -1 none).
  task automatic fetchMiss(input logic [26:0] a, input int clearAt);
    logic [26:0] base;
    base = {a[26:2], 2'b00};
    applyStimulus(a);
    waitSuperOe();
    checkOutput("miss super_oe latency", 32'(cyc), 32'(tOe + 2));
    step();
    serveBurst(base, clearAt);
    if (clearAt >= 0) begin
      modelClear();
      refillQ.push_back(base);
      waitSuperOe();
      checkOutput("dropped line re-request", 32'(cyc), 32'(lastWordCyc + 3));
      step();
      serveBurst(base, -1);
    end
    waitValid();
    checkOutput("miss valid latency", 32'(cyc), 32'(lastWordCyc + 2));
    modelFill(a);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    modelClear();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelClear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset super_oe", 32'(super_oe), 32'd0);
    checkOutput("reset cnt_hit", ic_cnt_hit, 32'd0);
    checkOutput("reset cnt_access", ic_cnt_access, 32'd0);
    checkOutput("reset cnt_refill", ic_cnt_refill, 32'd0);
    step();

    $display("[TB] cold miss 0x40 then hits 0x41..0x43");
    fetchMiss(27'h40, -1);
    checkOutput("cold miss rdata literal", rdata, 32'hA800_0040);
    checkOutput("cold miss super_addr literal", 32'(lastSuperAddr), 32'h40);
    fetchHit(27'h41);
    fetchHit(27'h42);
    fetchHit(27'h43);
    checkOutput("hit 0x43 rdata literal", rdata, 32'hA800_0043);
    step();
    step();
`ifdef ICACHE_STAT_EN
    checkOutput("stat access", ic_cnt_access, 32'd4);
    checkOutput("stat hit", ic_cnt_hit, 32'd3);
    checkOutput("stat refill", ic_cnt_refill, 32'd1);
`else
    checkOutput("stat access off", ic_cnt_access, 32'd0);
    checkOutput("stat hit off", ic_cnt_hit, 32'd0);
    checkOutput("stat refill off", ic_cnt_refill, 32'd0);
`endif

    $display("[TB] clear then mid-line miss 0x42");
    pulseClear();
    fetchMiss(27'h42, -1);
    checkOutput("mid-line super_addr literal", 32'(lastSuperAddr), 32'h40);
    checkOutput("mid-line rdata literal", rdata, 32'hA800_0042);

    $display("[TB] conflict 0x440 then 0x40");
    fetchMiss(27'h440, -1);
    checkOutput("conflict super_addr literal", 32'(lastSuperAddr), 32'h440);
    checkOutput("conflict rdata literal", rdata, 32'hA800_0440);
    fetchMiss(27'h40, -1);
    checkOutput("re-miss super_addr literal", 32'(lastSuperAddr), 32'h40);
    fetchHit(27'h41);

    $display("[TB] clear during fill after second word");
    pulseClear();
    fetchMiss(27'h40, 2);
    fetchHit(27'h43);

    $display("[TB] clear coincident with last word");
    pulseClear();
    fetchMiss(27'h84, 3);
    checkOutput("last-word clear rdata literal", rdata, 32'hA800_0084);

    $display("[TB] reset during fill");
    pulseClear();
    applyStimulus(27'h40);
    waitSuperOe();
    step();
    for (int i = 0; i < 2; i++) begin
      super_valid = 1'b1;
      super_rdata = 32'hDEAD_0000 | 32'(i);
      step();
    end
    rst_n = 1'b0;
    super_rdata = 32'hDEAD_0002;
    step();
    rst_n = 1'b1;
    super_rdata = 32'hDEAD_0003;
    checkOutput("post-reset ready", 32'(ready), 32'd1);
    checkOutput("post-reset valid", 32'(valid), 32'd0);
    checkOutput("post-reset super_oe", 32'(super_oe), 32'd0);
    expQ.delete();
    refillQ.delete();
    modelClear();
    step();
    super_valid = 1'b0;
    step();
    fetchMiss(27'h40, -1);
    checkOutput("after reset rdata literal", rdata, 32'hA800_0040);
    step();
    step();
`ifdef ICACHE_STAT_EN
    checkOutput("stat access after reset", ic_cnt_access, 32'd1);
    checkOutput("stat hit after reset", ic_cnt_hit, 32'd0);
    checkOutput("stat refill after reset", ic_cnt_refill, 32'd1);
`else
    checkOutput("stat access off after reset", ic_cnt_access, 32'd0);
`endif
    checkOutput("no outstanding fetches", 32'(expQ.size()), 32'd0);
    checkOutput("no outstanding refills", 32'(refillQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
